// File: rtl/tow_pkg.sv
// Shared definitions for the match controller and the LED mux:
// FSM state encoding and display-select codes.
package tow_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_CELEBRATE = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  localparam logic [1:0] DISP_SCORE = 2'b00;
  localparam logic [1:0] DISP_BLINK = 2'b01;
  localparam logic [1:0] DISP_TALLY = 2'b10;

  // Display mode shown while the controller sits in a given state.
  function automatic logic [1:0] disp_for_state(input state_e s);
    logic [1:0] d;
    case (s)
      ST_PLAY:               d = DISP_SCORE;
      ST_CELEBRATE, ST_DONE: d = DISP_BLINK;
      default:               d = DISP_TALLY;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/match_ctrl_tick_timer.sv
// tick_timer: loadable 8-bit down-counter clocked by slowenable ticks.
// done_o pulses for one clk on the tick that takes the count from 1 to 0.
// A load in the same clk as a tick wins; that tick is not counted.
module tick_timer
  import tow_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       tick_i,
  output logic       done_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: load, decrement on tick while non-zero, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = tick_i && !load_i && (count_q == 8'd1);

endmodule

// File: rtl/match_ctrl.sv
// match_ctrl: round/match sequencing for the tug-of-war game.
// Optional build macro MATCH_CTRL_AUTO_RESTART_EN: when defined, the end of
// the winner display clears the match and returns to the settle gap;
// otherwise the controller parks in DONE until reset.
module match_ctrl
  import tow_pkg::*;
#(
  parameter int unsigned WINS_TO_MATCH = 3,
  parameter int unsigned SETTLE_TICKS  = 32,
  parameter int unsigned HOLD_TICKS    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slowenable,
  input  logic       winrnd,
  input  logic       right,
  input  logic       tie,
  output logic       round_en,
  output logic [2:0] wins_l,
  output logic [2:0] wins_r,
  output logic       match_over,
  output logic       winner_right,
  output logic [1:0] disp_sel,
  output logic       blink
);

  localparam logic [2:0] WINS_C   = 3'(WINS_TO_MATCH);
  localparam logic [7:0] SETTLE_C = 8'(SETTLE_TICKS);
  localparam logic [7:0] HOLD_C   = 8'(HOLD_TICKS);

  state_e     state_q, state_d;
  logic [2:0] wins_l_q, wins_l_d;
  logic [2:0] wins_r_q, wins_r_d;
  logic       match_over_q, match_over_d;
  logic       winner_right_q, winner_right_d;
  logic       blink_q, blink_d;
  logic [2:0] blink_cnt_q, blink_cnt_d;
  logic       round_en_q;
  logic [1:0] disp_sel_q;

  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_done;

  tick_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tick_i     (slowenable),
    .done_o     (tmr_done)
  );

  // Next-state, score, and blink logic.
  always_comb begin
    state_d        = state_q;
    wins_l_d       = wins_l_q;
    wins_r_d       = wins_r_q;
    match_over_d   = match_over_q;
    winner_right_d = winner_right_q;
    blink_d        = blink_q;
    blink_cnt_d    = blink_cnt_q;
    tmr_load       = 1'b0;
    tmr_val        = 8'd0;
    case (state_q)
      ST_IDLE: begin
        if (slowenable) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAY: begin
        // A tick arriving with winrnd is simply not looked at here.
        if (winrnd && tie) begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_C;
        end else if (winrnd && (((right ? wins_r_q : wins_l_q) + 3'd1) == WINS_C)) begin
          if (right) begin
            wins_r_d = WINS_C;
          end else begin
            wins_l_d = WINS_C;
          end
          state_d        = ST_CELEBRATE;
          match_over_d   = 1'b1;
          winner_right_d = right;
          blink_d        = 1'b1;
          blink_cnt_d    = 3'd0;
          tmr_load       = 1'b1;
          tmr_val        = HOLD_C;
        end else if (winrnd) begin
          if (right) begin
            wins_r_d = wins_r_q + 3'd1;
          end else begin
            wins_l_d = wins_l_q + 3'd1;
          end
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_C;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_SETTLE: begin
        if (tmr_done) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_CELEBRATE: begin
        if (tmr_done) begin
`ifdef MATCH_CTRL_AUTO_RESTART_EN
          state_d        = ST_SETTLE;
          wins_l_d       = 3'd0;
          wins_r_d       = 3'd0;
          match_over_d   = 1'b0;
          winner_right_d = 1'b0;
          blink_d        = 1'b0;
          blink_cnt_d    = 3'd0;
          tmr_load       = 1'b1;
          tmr_val        = SETTLE_C;
`else
          state_d = ST_DONE;
          blink_d = 1'b1;
`endif
        end else if (slowenable) begin
          // Eight ticks per blink phase.
          blink_cnt_d = blink_cnt_q + 3'd1;
          if (blink_cnt_q == 3'd7) begin
            blink_d = ~blink_q;
          end else begin
            blink_d = blink_q;
          end
        end else begin
          state_d = ST_CELEBRATE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
        blink_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, score, and registered output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      wins_l_q       <= 3'd0;
      wins_r_q       <= 3'd0;
      match_over_q   <= 1'b0;
      winner_right_q <= 1'b0;
      blink_q        <= 1'b0;
      blink_cnt_q    <= 3'd0;
      round_en_q     <= 1'b0;
      disp_sel_q     <= DISP_TALLY;
    end else begin
      state_q        <= state_d;
      wins_l_q       <= wins_l_d;
      wins_r_q       <= wins_r_d;
      match_over_q   <= match_over_d;
      winner_right_q <= winner_right_d;
      blink_q        <= blink_d;
      blink_cnt_q    <= blink_cnt_d;
      round_en_q     <= (state_d == ST_PLAY);
      disp_sel_q     <= disp_for_state(state_d);
    end
  end

  assign round_en     = round_en_q;
  assign wins_l       = wins_l_q;
  assign wins_r       = wins_r_q;
  assign match_over   = match_over_q;
  assign winner_right = winner_right_q;
  assign disp_sel     = disp_sel_q;
  assign blink        = blink_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Self-checking bench for match_ctrl (default parameters) against a
// phase/remaining-ticks model derived from the game rules.
module tb_match_ctrl;

  localparam int WINS   = 3;
  localparam int SETTLE = 32;
  localparam int HOLD   = 64;

  localparam int P_IDLE   = 0;
  localparam int P_PLAY   = 1;
  localparam int P_SETTLE = 2;
  localparam int P_CELEB  = 3;
  localparam int P_DONE   = 4;

  logic       clk = 1'b0;
  logic       rst, slowenable, winrnd, right, tie;
  logic       round_en, match_over, winner_right, blink;
  logic [2:0] wins_l, wins_r;
  logic [1:0] disp_sel;

  int tests = 0;
  int fails = 0;

  int m_phase, m_wl, m_wr, m_over, m_win, m_left, m_el;

  match_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .slowenable   (slowenable),
    .winrnd       (winrnd),
    .right        (right),
    .tie          (tie),
    .round_en     (round_en),
    .wins_l       (wins_l),
    .wins_r       (wins_r),
    .match_over   (match_over),
    .winner_right (winner_right),
    .disp_sel     (disp_sel),
    .blink        (blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string ctx, input string name, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s observed=%0h expected=%0h", ctx, name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_wl = 0; m_wr = 0; m_over = 0; m_win = 0; m_left = 0; m_el = 0;
  endtask

  function automatic int exp_blink();
    if (m_phase == P_CELEB) return (((m_el / 8) % 2) == 0) ? 1 : 0;
    if (m_phase == P_DONE) return 1;
    return 0;
  endfunction

  function automatic int exp_disp();
    if (m_phase == P_PLAY) return 0;
    if (m_phase == P_CELEB || m_phase == P_DONE) return 1;
    return 2;
  endfunction

  task automatic check_all(input string ctx);
    chk(ctx, "round_en",     8'(round_en),     8'(m_phase == P_PLAY));
    chk(ctx, "wins_l",       8'(wins_l),       8'(m_wl));
    chk(ctx, "wins_r",       8'(wins_r),       8'(m_wr));
    chk(ctx, "match_over",   8'(match_over),   8'(m_over));
    chk(ctx, "winner_right", 8'(winner_right), 8'(m_win));
    chk(ctx, "disp_sel",     8'(disp_sel),     8'(exp_disp()));
    chk(ctx, "blink",        8'(blink),        8'(exp_blink()));
  endtask

  // Rule-level model of one clk with the given inputs.
  task automatic model_clk(input logic se, input logic w, input logic r, input logic t);
    int cnt;
    case (m_phase)
      P_IDLE: if (se) m_phase = P_PLAY;
      P_PLAY: begin
        if (w && t) begin
          m_phase = P_SETTLE; m_left = SETTLE;
        end else if (w) begin
          if (r) begin m_wr++; cnt = m_wr; end else begin m_wl++; cnt = m_wl; end
          if (cnt == WINS) begin
            m_phase = P_CELEB; m_over = 1; m_win = r ? 1 : 0; m_el = 0;
          end else begin
            m_phase = P_SETTLE; m_left = SETTLE;
          end
        end
      end
      P_SETTLE: if (se) begin
        m_left--;
        if (m_left == 0) m_phase = P_PLAY;
      end
      P_CELEB: if (se) begin
        m_el++;
        if (m_el == HOLD) begin
`ifdef MATCH_CTRL_AUTO_RESTART_EN
          m_wl = 0; m_wr = 0; m_over = 0; m_win = 0;
          m_phase = P_SETTLE; m_left = SETTLE;
`else
          m_phase = P_DONE;
`endif
        end
      end
      default: ;
    endcase
  endtask

  task automatic step(input logic se, input logic w, input logic r, input logic t, input string ctx);
    slowenable = se; winrnd = w; right = r; tie = t;
    @(posedge clk);
    model_clk(se, w, r, t);
    #1;
    slowenable = 1'b0; winrnd = 1'b0; right = 1'b0; tie = 1'b0;
    check_all(ctx);
  endtask

  // Random ticks (and ignored winrnd noise outside PLAY) until the model hits target.
  task automatic run_until(input int target, input int budget, input string ctx);
    int n = 0;
    while (m_phase != target && n < budget) begin
      step(logic'($urandom_range(0, 2) == 0),
           logic'((m_phase != P_PLAY) && ($urandom_range(0, 7) == 0)),
           logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), ctx);
      n++;
    end
    if (m_phase != target) begin
      tests++;
      fails++;
      $error("FAIL %s timeout observed_phase=%0d expected_phase=%0d", ctx, m_phase, target);
    end
  endtask

  // Linger in PLAY with ticks that must be ignored.
  task automatic play_idle(input string ctx);
    int n = int'($urandom_range(1, 4));
    for (int i = 0; i < n; i++) step(logic'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, ctx);
  endtask

  task automatic do_reset(input string ctx);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_all(ctx);
    rst = 1'b0;
  endtask

`ifdef MATCH_CTRL_AUTO_RESTART_EN
  localparam int END_PHASE = P_SETTLE;
`else
  localparam int END_PHASE = P_DONE;
`endif

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; slowenable = 1'b0; winrnd = 1'b0; right = 1'b0; tie = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Scenario 1: idle until first tick, then PLAY.
    step(1'b0, 1'b1, 1'b1, 1'b0, "idle_wr");
    step(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    step(1'b1, 1'b0, 1'b0, 1'b0, "to_play");

    // Scenarios 2-4: right takes the match, with a tie and a tick+winrnd collision.
    play_idle("play1");
    step(1'b0, 1'b1, 1'b1, 1'b0, "r_win1");
    run_until(P_PLAY, 2000, "settle1");
    step(1'b0, 1'b1, 1'b1, 1'b1, "tie");
    run_until(P_PLAY, 2000, "settle_tie");
    step(1'b1, 1'b1, 1'b1, 1'b0, "r_win2_tick");
    run_until(P_PLAY, 2000, "settle2");
    play_idle("play3");
    step(1'b0, 1'b1, 1'b1, 1'b0, "r_win3");
    run_until(END_PHASE, 2000, "celebrate1");
    for (int i = 0; i < 6; i++) step(logic'(i[0]), 1'b1, logic'(i[1]), 1'b0, "after1");

    // Scenario 5: left takes the match.
    do_reset("reset2");
    step(1'b1, 1'b0, 1'b0, 1'b0, "to_play2");
    for (int k = 0; k < WINS; k++) begin
      play_idle("play_l");
      step(1'b0, 1'b1, 1'b0, 1'b0, "l_win");
      if (m_phase == P_SETTLE) run_until(P_PLAY, 2000, "settle_l");
    end
    run_until(END_PHASE, 2000, "celebrate2");
`ifdef MATCH_CTRL_AUTO_RESTART_EN
    run_until(P_PLAY, 2000, "restart_settle");
    step(1'b0, 1'b1, 1'b1, 1'b0, "restart_win");
`endif

    // Scenario 6: asynchronous reset in the middle of the winner display.
    do_reset("reset3");
    step(1'b1, 1'b0, 1'b0, 1'b0, "to_play3");
    for (int k = 0; k < WINS; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, "r_fast");
      if (m_phase == P_SETTLE) run_until(P_PLAY, 2000, "settle_f");
    end
    for (int i = 0; i < 40 && m_phase == P_CELEB; i++) step(logic'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, "celeb3");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameter WINS_TO_MATCH, default 3, round wins needed to take the match; legal range 1..7.
REQ-002 Parameter SETTLE_TICKS, default 32, slowenable ticks of idle gap between rounds; legal range 1..255.
REQ-003 Parameter HOLD_TICKS, default 64, slowenable ticks of winner display; legal range 8..255.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 slowenable  in  1  one-clk tick, 1 of every 256 clk.
REQ-007 winrnd  in  1  one-clk pulse, round resolved.
REQ-008 right  in  1  1 = right player won the round; sampled with winrnd.
REQ-009 tie  in  1  1 = round was a tie; sampled with winrnd; overrides right.
REQ-010 round_en  out  1  permits the master controller to start or continue a round.
REQ-011 wins_l  out  3  left player round-win count.
REQ-012 wins_r  out  3  right player round-win count.
REQ-013 match_over  out  1  match decided.
REQ-014 winner_right  out  1  1 = right player took the match; valid while match_over=1.
REQ-015 disp_sel  out  2  LED mux mode: 00 score, 01 winner blink, 10 win tally.
REQ-016 blink  out  1  blink phase for disp_sel=01.

Function
REQ-017 FSM states: IDLE, PLAY, SETTLE, CELEBRATE, DONE.
REQ-018 IDLE -> PLAY on the first slowenable; in IDLE round_en=0 and disp_sel=10.
REQ-019 In PLAY, round_en=1 and disp_sel=00.
REQ-020 In PLAY, winrnd with tie=1 changes no count and enters SETTLE on the next clk.
REQ-021 In PLAY, winrnd with tie=0 increments wins_r if right=1, else wins_l, on the next clk.
REQ-022 If the incremented count equals WINS_TO_MATCH, the FSM enters CELEBRATE instead of SETTLE, sets match_over=1 and latches winner_right=right in the same clk.
REQ-023 round_en drops to 0 on the clk after the accepted winrnd, i.e. one-cycle latency.
REQ-024 In SETTLE, round_en=0 and disp_sel=10; after exactly SETTLE_TICKS slowenable ticks the FSM returns to PLAY.
REQ-025 winrnd outside PLAY is ignored: no count change, no state change.
REQ-026 The win counters never exceed WINS_TO_MATCH and never wrap.
REQ-027 In CELEBRATE, round_en=0 and disp_sel=01.
REQ-028 In CELEBRATE, blink starts at 1 and toggles every 8 slowenable ticks.
REQ-029 CELEBRATE lasts exactly HOLD_TICKS slowenable ticks, then goes to DONE.
REQ-030 In DONE, round_en=0, disp_sel=01, blink=1, and counts and match_over are held.
REQ-031 When slowenable and winrnd occur in the same clk in PLAY, winrnd is processed and the tick is discarded.
REQ-032 All outputs are registered, with no combinational path from input to output.

Reset
REQ-033 Reset values: state IDLE, round_en=0, wins_l=0, wins_r=0, match_over=0, winner_right=0, disp_sel=10, blink=0, and all tick counters 0.
REQ-034 Reset asserted in any state, including mid-CELEBRATE, takes effect immediately and discards the match in progress.

Configuration
REQ-035 The macro MATCH_CTRL_AUTO_RESTART_EN selects the end-of-CELEBRATE behaviour.
REQ-036 With MATCH_CTRL_AUTO_RESTART_EN defined, CELEBRATE expiry clears wins_l, wins_r, match_over and winner_right and enters SETTLE; DONE is unreachable.
REQ-037 Without MATCH_CTRL_AUTO_RESTART_EN, CELEBRATE expiry enters DONE, which is left only by rst.

Structure
REQ-038 Shared package tow_pkg holds the FSM state encoding and the disp_sel codes DISP_SCORE=00, DISP_BLINK=01 and DISP_TALLY=10, for reuse by ledmux.
REQ-039 One sub-module, tick_timer, is a loadable 8-bit down-counter that decrements on slowenable and emits a one-clk done pulse; it is shared by SETTLE and CELEBRATE.

Verification
REQ-040 Scenario 1: rst, then one slowenable -> state PLAY, round_en=1 on the next clk, wins_l=0, wins_r=0.
REQ-041 Scenario 2: three winrnd pulses with right=1, each after SETTLE -> wins_r=1, 2, 3; on the third, match_over=1, winner_right=1, disp_sel=01 and blink=1.
REQ-042 Scenario 3: winrnd with tie=1 and right=1 -> counts unchanged, SETTLE entered, round_en=0 for exactly 32 ticks, then 1.
REQ-043 Scenario 4: winrnd pulsed during SETTLE and during CELEBRATE -> counts and state unchanged.
REQ-044 Scenario 5: wins_l reaches 3 -> blink toggles every 8 ticks; after 64 ticks the FSM is in DONE (macro off) or counts are 0 and the FSM is in SETTLE (macro on).
REQ-045 Scenario 6: rst asserted mid-CELEBRATE, asynchronous to clk -> all outputs at reset values before the next clk edge.
